// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the register slave: response codes,
// data/strobe widths, the W-channel payload and the byte-merge helper.
package axil_pkg;

   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned STRB_WIDTH = 4;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // One W-channel beat as held in the write-data buffer
   typedef struct packed {
      logic [STRB_WIDTH-1:0] strb;
      logic [DATA_WIDTH-1:0] data;
   } w_beat_t;

   // Replace the bytes of old_v selected by strb with the bytes of new_v
   function automatic logic [DATA_WIDTH-1:0] byte_merge(
      input logic [DATA_WIDTH-1:0] old_v,
      input logic [DATA_WIDTH-1:0] new_v,
      input logic [STRB_WIDTH-1:0] strb
   );
      logic [DATA_WIDTH-1:0] v;
      v = old_v;
      for (int b = 0; b < int'(STRB_WIDTH); b++) begin
         if (strb[b]) v[8*b +: 8] = new_v[8*b +: 8];
      end
      return v;
   endfunction

endpackage

// File: rtl/axil_skid1.sv
// One-entry capture buffer for an AXI-Lite request channel.
// Ports:
//   clk        clock
//   i_rst      synchronous active-high reset (buffer emptied, ready low)
//   i_valid    channel VALID
//   o_ready_c  channel READY (buffer empty and not in reset)
//   i_data     channel payload
//   i_clear    consumer took the entry this cycle
//   o_have_c   an entry is available now (held, or arriving this cycle)
//   o_data_c   held payload, or the live payload when arriving this cycle
module axil_skid1 #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready_c,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_clear,
   output logic             o_have_c,
   output logic [WIDTH-1:0] o_data_c
);

   logic             r_full;
   logic [WIDTH-1:0] r_data;
   logic             w_hs;

   assign o_ready_c = !r_full && !i_rst;
   assign w_hs      = i_valid && o_ready_c;
   assign o_have_c  = r_full || w_hs;
   // Bypass lets a same-cycle handshake be consumed without a bubble
   assign o_data_c  = r_full ? r_data : i_data;

   // Entry state; a clear takes priority since a bypassed beat is consumed directly
   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_full <= 1'b0;
         r_data <= '0;
      end else if (i_clear) begin
         r_full <= 1'b0;
      end else if (w_hs) begin
         r_full <= 1'b1;
         r_data <= i_data;
      end
   end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave exposing a bank of 32-bit control registers.
// Register 0 is a read-only ID; registers 1..NUM_REGS-1 are read/write with
// byte strobes and are driven out on REG_OUT together with per-register
// write pulses on WR_STROBE.
// Ports:
//   ACLK, ARESET                     clock, synchronous active-high reset
//   AW*/W*/B*                        write address, data and response channels
//   AR*/R*                           read address and data channels
//   REG_OUT[32i+31:32i]              contents of register i (reg 0 = ID_VALUE)
//   WR_STROBE[i]                     one-cycle pulse after a committed write to reg i
module axil_reg_slave
   import axil_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned NUM_REGS   = 8,
   parameter logic [31:0] ID_VALUE   = 32'h4E58_4D55
) (
   input  logic                           ACLK,
   input  logic                           ARESET,
   output logic                           AWREADY,
   input  logic                           AWVALID,
   input  logic [ADDR_WIDTH-1:0]          AWADDR,
   output logic                           WREADY,
   input  logic                           WVALID,
   input  logic [STRB_WIDTH-1:0]          WSTRB,
   input  logic [DATA_WIDTH-1:0]          WDATA,
   output logic [1:0]                     BRESP,
   output logic                           BVALID,
   input  logic                           BREADY,
   output logic                           ARREADY,
   input  logic                           ARVALID,
   input  logic [ADDR_WIDTH-1:0]          ARADDR,
   output logic [DATA_WIDTH-1:0]          RDATA,
   output logic [1:0]                     RRESP,
   output logic                           RVALID,
   input  logic                           RREADY,
   output logic [NUM_REGS*DATA_WIDTH-1:0] REG_OUT,
   output logic [NUM_REGS-1:0]            WR_STROBE
);

   localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int unsigned CMP_W = ADDR_WIDTH + 32;

   logic                  w_aw_have;
   logic [ADDR_WIDTH-1:0] w_awaddr;
   logic                  w_w_have;
   w_beat_t               w_wbeat_in;
   w_beat_t               w_wbeat;
   logic                  w_commit;
   logic [IDX_W-1:0]      w_wr_idx;
   logic                  w_wr_ok;
   logic                  w_rd_hs;
   logic [IDX_W-1:0]      w_rd_idx;
   logic                  w_rd_ok;

   logic [NUM_REGS-1:1][DATA_WIDTH-1:0] r_regs;
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] w_regs;

   logic                  r_bvalid;
   logic [1:0]            r_bresp;
   logic [NUM_REGS-1:0]   r_wr_strobe;
   logic                  r_rvalid;
   logic [1:0]            r_rresp;
   logic [DATA_WIDTH-1:0] r_rdata;

   assign w_wbeat_in = {WSTRB, WDATA};

   // Write-address buffer
   axil_skid1 #(.WIDTH(ADDR_WIDTH)) u_aw_buf (
      .clk       (ACLK),
      .i_rst     (ARESET),
      .i_valid   (AWVALID),
      .o_ready_c (AWREADY),
      .i_data    (AWADDR),
      .i_clear   (w_commit),
      .o_have_c  (w_aw_have),
      .o_data_c  (w_awaddr)
   );

   // Write-data buffer
   axil_skid1 #(.WIDTH($bits(w_beat_t))) u_w_buf (
      .clk       (ACLK),
      .i_rst     (ARESET),
      .i_valid   (WVALID),
      .o_ready_c (WREADY),
      .i_data    (w_wbeat_in),
      .i_clear   (w_commit),
      .o_have_c  (w_w_have),
      .o_data_c  (w_wbeat)
   );

   // A write commits once both halves are present and the B slot is free or draining
   assign w_commit = w_aw_have && w_w_have && (!r_bvalid || BREADY);

   // Address is in range iff ADDR >> 2 < NUM_REGS, i.e. ADDR < 4*NUM_REGS
   assign w_wr_idx = w_awaddr[2 +: IDX_W];
   assign w_wr_ok  = ({32'd0, w_awaddr} < CMP_W'(NUM_REGS * 4)) && (w_wr_idx != '0);

   assign w_rd_idx = ARADDR[2 +: IDX_W];
   assign w_rd_ok  = ({32'd0, ARADDR} < CMP_W'(NUM_REGS * 4));
   assign ARREADY  = !r_rvalid && !ARESET;
   assign w_rd_hs  = ARVALID && ARREADY;

   // Full register view with the ID in slot 0
   assign w_regs  = {r_regs, ID_VALUE};
   assign REG_OUT = w_regs;

   // Register bank updates and write pulses
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_regs      <= '0;
         r_wr_strobe <= '0;
      end else begin
         for (int i = 1; i < int'(NUM_REGS); i++) begin
            if (w_commit && w_wr_ok && (w_wr_idx == IDX_W'(i))) begin
               r_regs[i] <= byte_merge(r_regs[i], w_wbeat.data, w_wbeat.strb);
            end
         end
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            r_wr_strobe[i] <= w_commit && w_wr_ok && (w_wr_idx == IDX_W'(i));
         end
      end
   end

   // Write response; held until BREADY, may reload on the handshake edge
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_bvalid <= 1'b0;
         r_bresp  <= RESP_OKAY;
      end else if (w_commit) begin
         r_bvalid <= 1'b1;
         r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (BREADY) begin
         r_bvalid <= 1'b0;
      end
   end

   // Read response; samples the bank before any same-edge write lands
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_rvalid <= 1'b0;
         r_rresp  <= RESP_OKAY;
         r_rdata  <= '0;
      end else if (w_rd_hs) begin
         r_rvalid <= 1'b1;
         r_rresp  <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
         r_rdata  <= w_rd_ok ? w_regs[w_rd_idx] : '0;
      end else if (RREADY) begin
         r_rvalid <= 1'b0;
      end
   end

   assign BVALID    = r_bvalid;
   assign BRESP     = r_bresp;
   assign WR_STROBE = r_wr_strobe;
   assign RVALID    = r_rvalid;
   assign RRESP     = r_rresp;
   assign RDATA     = r_rdata;

endmodule

// File: doc/axil_reg_slave.md
Name: axil_reg_slave

Overview:
- AXI4-Lite slave endpoint instantiated inside the AXI-Lite adapter top.
- Consumes the five AXI-Lite channels and exposes a bank of 32-bit control registers to the emulated RTL.
- Register 0 is a read-only ID. Registers 1..NUM_REGS-1 are read/write with byte strobes; their contents and per-register write pulses are driven out to the design under emulation.

Parameters:
- ADDR_WIDTH, 32: width of AWADDR/ARADDR.
- NUM_REGS, 8: number of 32-bit registers, 2..256.
- ID_VALUE, 32'h4E58_4D55: constant returned by register 0.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous reset, active-high.
- AWREADY  out  1  write-address ready.
- AWVALID  in  1  write-address valid.
- AWADDR  in  ADDR_WIDTH  write address.
- WREADY  out  1  write-data ready.
- WVALID  in  1  write-data valid.
- WSTRB  in  4  byte enables.
- WDATA  in  32  write data.
- BRESP  out  2  write response.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- ARREADY  out  1  read-address ready.
- ARVALID  in  1  read-address valid.
- ARADDR  in  ADDR_WIDTH  read address.
- RDATA  out  32  read data.
- RRESP  out  2  read response.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.
- REG_OUT  out  NUM_REGS*32  flattened register contents; reg i occupies bits [32i+31:32i].
- WR_STROBE  out  NUM_REGS  one-cycle pulse per register on committed write.

Behaviour:
- Clocking/reset: one clock, ACLK. Reset ARESET is synchronous and active-high.
- Values while ARESET is high:
  - AWREADY, WREADY, ARREADY, BVALID, RVALID, WR_STROBE = 0.
  - BRESP, RRESP = 2'b00; RDATA = 0.
  - Registers 1..N-1 = 0; holding buffers cleared.
  - Reset mid-transaction discards all pending state; no response is issued afterwards.
- Decode:
  - index = ADDR[2+IDX_W-1:2], where IDX_W = clog2(NUM_REGS). ADDR[1:0] is ignored.
  - Address valid iff ADDR >> 2 < NUM_REGS.
- Write path:
  - AW and W are captured independently into one-entry buffers (aw_full, w_full), in either order.
  - AWREADY = !aw_full; WREADY = !w_full (both 0 in reset).
  - Commit condition on an edge: (aw_full | AW handshake) & (w_full | W handshake) & (!BVALID | BREADY).
  - At commit:
    - Valid index >= 1: register bytes with WSTRB[b]=1 are updated; BRESP = OKAY (2'b00); WR_STROBE[index] pulses in the following cycle.
    - Index 0 or out of range: no update; BRESP = SLVERR (2'b10).
    - BVALID is set; both buffers are cleared.
  - Latency: BVALID rises the cycle after the last of the AW/W handshakes.
  - BVALID and BRESP are held stable until BREADY; a new commit may coincide with the B handshake edge.
  - WSTRB = 0 on a valid register: OKAY, no data change, WR_STROBE still pulses.
- Read path:
  - ARREADY = !RVALID.
  - On AR handshake, RDATA/RRESP are registered and RVALID = 1 in the next cycle:
    - Index 0: ID_VALUE, OKAY.
    - Valid index: register value, OKAY.
    - Out of range: RDATA = 0, SLVERR.
  - RVALID, RDATA, RRESP are held until RREADY.
  - Latency: 1 cycle from AR handshake to RVALID.
- Simultaneous events:
  - Read and write commit on the same register at the same edge: the read returns the pre-write value.
  - Read and write channels are fully independent; no ordering between them.
- REG_OUT is registered state, valid the cycle after commit; bits [31:0] = ID_VALUE.

Decomposition:
- Shared package axil_pkg:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - DATA_WIDTH = 32, STRB_WIDTH = 4.
  - Function byte_merge(old, new, strb).
- One natural sub-module: axil_skid1, a one-entry capture buffer (valid/ready in, data out, clear). Instantiated twice, for AW and W.

Test Plan:
- Reset, then AW=0x4 and W=0x1234_5678 with strobe 0xF in the same cycle -> BVALID=1 next cycle, BRESP=00, WR_STROBE[1] pulse, REG_OUT[63:32]=0x1234_5678.
- W first, AW=0x8 three cycles later, WSTRB=0x3, data 0xAABB_CCDD over old 0 -> reg2=0x0000_CCDD, BVALID the cycle after the AW handshake.
- Read addr 0x0 -> RDATA=0x4E58_4D55, OKAY. Read addr 0x20 (NUM_REGS=8) -> RDATA=0, RRESP=10. Write to 0x0 -> BRESP=10, reg 0 unchanged.
- BREADY held low 5 cycles with a second AW/W pending -> BVALID/BRESP stable, AWREADY=WREADY=0 after capture; second commit on the BREADY edge.
- Read reg3 while a write of 0x5 commits to reg3 on the same edge (old 0x9) -> RDATA=0x9; a subsequent read returns 0x5.
- Assert ARESET for 1 cycle while BVALID=1 and an AW is buffered -> all outputs 0, registers 0; no BVALID after reset.
